// File: rtl/pbus_pkg.sv
// Shared definitions for the PBus initiator: FSM state encoding, strobe levels, default widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pbus_pkg;

    typedef enum logic [1:0] {
        ST_BUSRST  = 2'd0,
        ST_IDLE    = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } pbus_state_e;

    // PBus strobes are active low
    localparam logic STROBE_IDLE   = 1'b1;
    localparam logic STROBE_ACTIVE = 1'b0;

    localparam int PBUS_ADDR_W = 16;
    localparam int PBUS_DATA_W = 32;

    localparam int WAIT_CNT_W = 8;
    localparam int REC_CNT_W  = 4;
    localparam int RST_CNT_W  = 8;

endpackage

// File: rtl/pbus_down_counter.sv
// Loadable down-counter that saturates at zero and flags it; used for wait, recovery and reset-stretch timing.
// Latency: load/decrement take effect on the next Clk edge; zero is decoded from the register.
// Backpressure: none; load has priority over decrement.
//   clk/rst   : clock, asynchronous active-high reset (count returns to RST_VAL)
//   load_en   : load load_val on the next edge
//   dec_en    : decrement by one on the next edge (ignored at zero)
//   zero      : count is zero
module pbus_down_counter #(
    parameter int             W       = 8,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    input  logic         dec_en,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_en) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pbus_master.sv
// PBus initiator: turns one valid/ready request into one PBusRDN/PBusWRN strobe cycle, stretches bus reset, reports timeouts.
// Latency: strobe visible the cycle after the accept edge; zero-wait completion pulses RspValid two cycles after the accept cycle.
// Backpressure: ReqReady is high only in IDLE; low through bus reset, the strobe and RECOVERY cycles afterwards.
//   Req*        : request port (ReqValid/ReqReady handshake, ReqWrite, ReqAddr, ReqWData)
//   Rsp*        : completion pulse RspValid, RspRData (reads), RspTimeout (abort)
//   PBus*       : bus side; all outputs registered, strobes and PBusReadyN active low
module pbus_master
    import pbus_pkg::*;
#(
    parameter int ADDR_WIDTH   = PBUS_ADDR_W,
    parameter int DATA_WIDTH   = PBUS_DATA_W,
    parameter int TIMEOUT      = 15,
    parameter int RECOVERY     = 2,
    parameter int RESET_CYCLES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddr,
    input  logic [DATA_WIDTH-1:0] ReqWData,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] RspRData,
    output logic                  RspTimeout,
    output logic                  PBusResetN,
    output logic                  PBusRDN,
    output logic                  PBusWRN,
    output logic [ADDR_WIDTH-1:0] PBusAddr,
    output logic [DATA_WIDTH-1:0] PBusDataOut,
    output logic                  PBusDataOE,
    input  logic [DATA_WIDTH-1:0] PBusDataIn,
    input  logic                  PBusReadyN
);

    // Counters are loaded with N-1 so that the zero flag marks the N-th edge
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(TIMEOUT - 1);
    localparam logic [REC_CNT_W-1:0]  REC_LOAD  = REC_CNT_W'(RECOVERY - 1);
    localparam logic [RST_CNT_W-1:0]  RST_LOAD  = RST_CNT_W'(RESET_CYCLES - 1);

    pbus_state_e           state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  bus_reset_n_q, bus_reset_n_d;
    logic                  rd_n_q, rd_n_d;
    logic                  wr_n_q, wr_n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  oe_q, oe_d;

    logic rst_zero, wait_zero, rec_zero;
    logic accept, ready_seen, timed_out, xfer_done;

    assign accept     = (state_q == ST_IDLE) && req_ready_q && ReqValid;
    assign ready_seen = (state_q == ST_STROBE) && !PBusReadyN;
    // A ready on the timeout edge takes precedence over the abort
    assign timed_out  = (state_q == ST_STROBE) && PBusReadyN && wait_zero;
    assign xfer_done  = ready_seen || timed_out;

    // Reset stretch: starts at RESET_CYCLES-1 straight out of reset, only reloaded by Reset
    pbus_down_counter #(.W(RST_CNT_W), .RST_VAL(RST_LOAD)) u_rst_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load_en  (1'b0),
        .load_val ('0),
        .dec_en   ((state_q == ST_BUSRST) && !rst_zero),
        .zero     (rst_zero)
    );

    pbus_down_counter #(.W(WAIT_CNT_W), .RST_VAL('0)) u_wait_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load_en  (accept),
        .load_val (WAIT_LOAD),
        .dec_en   ((state_q == ST_STROBE) && PBusReadyN),
        .zero     (wait_zero)
    );

    pbus_down_counter #(.W(REC_CNT_W), .RST_VAL('0)) u_rec_cnt (
        .clk      (Clk),
        .rst      (Reset),
        .load_en  (xfer_done),
        .load_val (REC_LOAD),
        .dec_en   (state_q == ST_RECOVER),
        .zero     (rec_zero)
    );

    // State and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_BUSRST;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            bus_reset_n_q <= 1'b0;
            rd_n_q        <= STROBE_IDLE;
            wr_n_q        <= STROBE_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            oe_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_rdata_q   <= rsp_rdata_d;
            bus_reset_n_q <= bus_reset_n_d;
            rd_n_q        <= rd_n_d;
            wr_n_q        <= wr_n_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            oe_q          <= oe_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_BUSRST:  if (rst_zero)  state_d = ST_IDLE;
            ST_IDLE:    if (accept)    state_d = ST_STROBE;
            ST_STROBE:  if (xfer_done) state_d = ST_RECOVER;
            ST_RECOVER: if (rec_zero)  state_d = ST_IDLE;
            default:                   state_d = ST_BUSRST;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        req_ready_d   = req_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        bus_reset_n_d = bus_reset_n_q;
        rd_n_d        = rd_n_q;
        wr_n_d        = wr_n_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        oe_d          = oe_q;
        unique case (state_q)
            ST_BUSRST: begin
                // ReqReady stays low on the release edge; it rises one edge into IDLE
                req_ready_d = 1'b0;
                if (rst_zero) begin
                    bus_reset_n_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    addr_d      = ReqAddr;
                    wdata_d     = ReqWData;
                    if (ReqWrite) begin
                        wr_n_d = STROBE_ACTIVE;
                        oe_d   = 1'b1;
                    end else begin
                        rd_n_d = STROBE_ACTIVE;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_STROBE: begin
                req_ready_d = 1'b0;
                if (xfer_done) begin
                    rd_n_d        = STROBE_IDLE;
                    wr_n_d        = STROBE_IDLE;
                    oe_d          = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = !ready_seen;
                    // The active read strobe tells us this is a read
                    if (ready_seen && (rd_n_q == STROBE_ACTIVE)) begin
                        rsp_rdata_d = PBusDataIn;
                    end
                end
            end
            ST_RECOVER: begin
                req_ready_d = rec_zero;
            end
            default: begin
                req_ready_d = 1'b0;
            end
        endcase
    end

    assign ReqReady    = req_ready_q;
    assign RspValid    = rsp_valid_q;
    assign RspTimeout  = rsp_timeout_q;
    assign RspRData    = rsp_rdata_q;
    assign PBusResetN  = bus_reset_n_q;
    assign PBusRDN     = rd_n_q;
    assign PBusWRN     = wr_n_q;
    assign PBusAddr    = addr_q;
    assign PBusDataOut = wdata_q;
    assign PBusDataOE  = oe_q;

endmodule

// File: tb/tb_pbus_master.sv
// Self-checking bench for pbus_master: schedule-based transaction model, per-cycle compare, literal timing pins.
// Latency: n/a.
// Backpressure: requests held on ReqValid until the model says ReqReady is high.
module tb_pbus_master;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 15;
    localparam int REC = 2;
    localparam int RSC = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic [AW-1:0] ReqAddr;
    logic [DW-1:0] ReqWData;
    logic          RspValid;
    logic [DW-1:0] RspRData;
    logic          RspTimeout;
    logic          PBusResetN;
    logic          PBusRDN;
    logic          PBusWRN;
    logic [AW-1:0] PBusAddr;
    logic [DW-1:0] PBusDataOut;
    logic          PBusDataOE;
    logic [DW-1:0] PBusDataIn;
    logic          PBusReadyN;

    pbus_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO), .RECOVERY(REC), .RESET_CYCLES(RSC)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RspValid(RspValid), .RspRData(RspRData), .RspTimeout(RspTimeout),
        .PBusResetN(PBusResetN), .PBusRDN(PBusRDN), .PBusWRN(PBusWRN),
        .PBusAddr(PBusAddr), .PBusDataOut(PBusDataOut), .PBusDataOE(PBusDataOE),
        .PBusDataIn(PBusDataIn), .PBusReadyN(PBusReadyN)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            waits;   // strobe cycles with ReadyN high before it goes low
        logic [DW-1:0] rdval;
    } tx_t;

    tx_t txq[$];
    tx_t pend, cur;
    bit  have_pend, directed, in_tx, to;
    int  cyc, t_acc, k, ready_from;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_dout, exp_rdata;

    int n_vec = 0;
    int n_mis = 0;

    // Observations for literal checks
    int first_rstn, first_rdy;
    int n_acc = 0;
    int n_rsp = 0;
    int acc_cyc[16];
    int rsp_cyc[16];
    logic [DW-1:0] rsp_dat[16];
    logic rsp_to[16];
    int strobe_cnt[16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        cyc        = 0;
        in_tx      = 1'b0;
        to         = 1'b0;
        k          = 0;
        t_acc      = 0;
        ready_from = RSC + 1;
        exp_addr   = '0;
        exp_dout   = '0;
        exp_rdata  = '0;
        have_pend  = 1'b0;
        first_rstn = -1;
        first_rdy  = -1;
    endtask

    // Compare DUT outputs of the current cycle against the schedule
    task automatic check_cycle();
        bit strobe_on, e_rv;
        if (in_tx && (cyc == t_acc + k + 1) && !to && !cur.wr)
            exp_rdata = cur.rdval;
        strobe_on = in_tx && (cyc >= t_acc + 1) && (cyc <= t_acc + k);
        e_rv      = in_tx && (cyc == t_acc + k + 1);
        chk("ReqReady",    ReqReady,    cyc >= ready_from);
        chk("RspValid",    RspValid,    e_rv);
        chk("RspTimeout",  RspTimeout,  e_rv && to);
        chk("RspRData",    RspRData,    exp_rdata);
        chk("PBusResetN",  PBusResetN,  cyc >= RSC);
        chk("PBusRDN",     PBusRDN,     !(strobe_on && !cur.wr));
        chk("PBusWRN",     PBusWRN,     !(strobe_on && cur.wr));
        chk("PBusDataOE",  PBusDataOE,  strobe_on && cur.wr);
        chk("PBusAddr",    PBusAddr,    exp_addr);
        chk("PBusDataOut", PBusDataOut, exp_dout);
        chk("both_strobes_low", !PBusRDN && !PBusWRN, 1'b0);
        if (first_rstn < 0 && PBusResetN === 1'b1) first_rstn = cyc;
        if (first_rdy < 0 && ReqReady === 1'b1)    first_rdy  = cyc;
        if (RspValid === 1'b1 && n_rsp < 16) begin
            rsp_cyc[n_rsp] = cyc;
            rsp_dat[n_rsp] = RspRData;
            rsp_to[n_rsp]  = RspTimeout;
        end
        if (RspValid === 1'b1) n_rsp++;
        if (n_acc > 0 && n_acc <= 16 && (PBusRDN === 1'b0 || PBusWRN === 1'b0))
            strobe_cnt[n_acc-1]++;
    endtask

    // Drive inputs for the current cycle (sampled at the next rising edge)
    task automatic drive_cycle();
        if (!have_pend && txq.size() > 0 && (directed || $urandom_range(0, 2) != 0)) begin
            pend      = txq.pop_front();
            have_pend = 1'b1;
        end
        if (have_pend) begin
            ReqValid = 1'b1;
            ReqWrite = pend.wr;
            ReqAddr  = pend.addr;
            ReqWData = pend.wdata;
            if (cyc >= ready_from) begin
                t_acc = cyc;
                cur   = pend;
                in_tx = 1'b1;
                if (pend.waits + 1 <= TMO) begin
                    k  = pend.waits + 1;
                    to = 1'b0;
                end else begin
                    k  = TMO;
                    to = 1'b1;
                end
                ready_from = cyc + k + REC + 1;
                exp_addr   = pend.addr;
                exp_dout   = pend.wdata;
                if (n_acc < 16) acc_cyc[n_acc] = cyc;
                n_acc++;
                have_pend = 1'b0;
            end
        end else begin
            ReqValid = 1'b0;
            ReqWrite = 1'($urandom_range(0, 1));
            ReqAddr  = AW'($urandom);
            ReqWData = $urandom;
        end
        PBusDataIn = $urandom;
        if (in_tx && (cyc >= t_acc + 1) && (cyc <= t_acc + k)) begin
            PBusReadyN = (cyc == t_acc + k && !to) ? 1'b0 : 1'b1;
            if (cyc == t_acc + k && !to && !cur.wr) PBusDataIn = cur.rdval;
        end else begin
            PBusReadyN = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic step();
        @(posedge Clk);
        cyc++;
        @(negedge Clk);
        check_cycle();
        drive_cycle();
    endtask

    task automatic run_until_idle(input int budget, input string nm);
        int n = 0;
        while (!(txq.size() == 0 && !have_pend && cyc >= ready_from) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            n_vec++;
            n_mis++;
            $display("FAIL %s no completion within %0d cycles", nm, budget);
        end
    endtask

    function automatic tx_t mk(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input int w, input logic [DW-1:0] rv);
        tx_t t;
        t.wr = wr; t.addr = a; t.wdata = d; t.waits = w; t.rdval = rv;
        return t;
    endfunction

    initial begin
        int n, n0;
        Reset = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddr = '0; ReqWData = '0;
        PBusDataIn = '0; PBusReadyN = 1'b1;
        directed = 1'b1;
        for (int i = 0; i < 16; i++) strobe_cnt[i] = 0;
        model_reset();
        repeat (2) begin
            @(negedge Clk);
            check_cycle();
        end
        Reset = 1'b0;
        drive_cycle();

        // Directed: write, 3-cycle read, timeout read, 8 alternating back-to-back
        txq.push_back(mk(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'h0));
        txq.push_back(mk(1'b0, 16'h0004, 32'h0, 2, 32'h12345678));
        txq.push_back(mk(1'b0, 16'h0008, 32'h0, 40, 32'hCAFEF00D));
        for (int i = 0; i < 8; i++)
            txq.push_back(mk(1'(i % 2), AW'(16'h0100 + i), 32'hA5A50000 + i, 0, 32'h5A5A0000 + i));
        run_until_idle(2000, "directed");

        chk("rstn_rise_cycle",      first_rstn, 4);
        chk("first_ready_cycle",    first_rdy, 5);
        chk("wr_rsp_latency",       rsp_cyc[0] - acc_cyc[0], 2);
        chk("wr_rsp_timeout",       rsp_to[0], 1'b0);
        chk("wr_strobe_len",        strobe_cnt[0], 1);
        chk("wr_recovery_gap",      acc_cyc[1] - rsp_cyc[0], 2);
        chk("rd_rsp_latency",       rsp_cyc[1] - acc_cyc[1], 4);
        chk("rd_strobe_len",        strobe_cnt[1], 3);
        chk("rd_rdata",             rsp_dat[1], 32'h12345678);
        chk("rd_timeout_flag",      rsp_to[1], 1'b0);
        chk("tmo_strobe_len",       strobe_cnt[2], 15);
        chk("tmo_flag",             rsp_to[2], 1'b1);
        chk("tmo_rdata_kept",       rsp_dat[2], 32'h12345678);
        for (int i = 3; i < 10; i++) chk("b2b_spacing", acc_cyc[i+1] - acc_cyc[i], 4);
        for (int i = 3; i < 11; i++) chk("b2b_no_timeout", rsp_to[i], 1'b0);
        chk("rsp_count", n_rsp, 11);

        // Reset while a read strobe is active
        n0 = n_acc;
        n  = 0;
        txq.push_back(mk(1'b0, 16'h0BAD, 32'h0, 40, 32'h0));
        while (!(n_acc > n0 && cyc == t_acc + 3) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_mis++;
            $display("FAIL kill_setup read never accepted");
        end
        chk("pre_kill_rdn", PBusRDN, 1'b0);
        #2 Reset = 1'b1;
        #1;
        chk("kill_rdn",   PBusRDN, 1'b1);
        chk("kill_wrn",   PBusWRN, 1'b1);
        chk("kill_oe",    PBusDataOE, 1'b0);
        chk("kill_rstn",  PBusResetN, 1'b0);
        chk("kill_rsp",   RspValid, 1'b0);
        chk("kill_ready", ReqReady, 1'b0);
        model_reset();
        ReqValid = 1'b0;
        PBusReadyN = 1'b1;
        repeat (2) begin
            @(negedge Clk);
            check_cycle();
        end
        Reset = 1'b0;
        drive_cycle();

        // Random traffic with gaps, including waits around the timeout boundary
        directed = 1'b0;
        for (int i = 0; i < 300; i++) begin
            int w;
            w = ($urandom_range(0, 7) < 6) ? int'($urandom_range(0, 4)) : int'($urandom_range(13, 17));
            txq.push_back(mk(1'($urandom_range(0, 1)), AW'($urandom), $urandom, w, $urandom));
        end
        run_until_idle(30000, "random");
        chk("post_kill_rstn_rise",  first_rstn, 4);
        chk("post_kill_first_rdy",  first_rdy, 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
